// File: rtl/morse_pkg.sv
// morse_pkg
// Shared definitions for the Morse letter sequencer:
//   - state_t        : sequencer FSM states (IDLE, MARK, GAP)
//   - LETTER_INVALID : first letter code that has no Morse entry (26)
//   - DASH_UNITS / DOT_UNITS : mark lengths in Morse units
//   - MORSE_TABLE    : 26 entries of {len[2:0], pat[3:0]}, indexed by letter.
//     pat bit 0 is the first symbol sent, and 1 means dash. Unused pattern
//     bits above len are 0.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MARK = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int LETTER_INVALID = 26;
    localparam int DASH_UNITS     = 3;
    localparam int DOT_UNITS      = 1;

    // Packed so that element [n] is letter n (A = 0). The listing below runs Z down to A.
    localparam logic [25:0][6:0] MORSE_TABLE = {
        7'b100_0011,  // Z --..
        7'b100_1101,  // Y -.--
        7'b100_1001,  // X -..-
        7'b011_0110,  // W .--
        7'b100_1000,  // V ...-
        7'b011_0100,  // U ..-
        7'b001_0001,  // T -
        7'b011_0000,  // S ...
        7'b011_0010,  // R .-.
        7'b100_1011,  // Q --.-
        7'b100_0110,  // P .--.
        7'b011_0111,  // O ---
        7'b010_0001,  // N -.
        7'b010_0011,  // M --
        7'b100_0010,  // L .-..
        7'b011_0101,  // K -.-
        7'b100_1110,  // J .---
        7'b010_0000,  // I ..
        7'b100_0000,  // H ....
        7'b011_0011,  // G --.
        7'b100_0100,  // F ..-.
        7'b001_0000,  // E .
        7'b011_0001,  // D -..
        7'b100_0101,  // C -.-.
        7'b100_0001,  // B -...
        7'b010_0010   // A .-
    };

endpackage

// File: rtl/morse_rom.sv
// morse_rom
// Purely combinational letter lookup.
// Ports:
//   letter [4:0] : letter code, 0 = A ... 25 = Z, 26..31 are invalid
//   valid        : 1 when letter is in the table
//   len    [2:0] : symbol count, 1..4 (0 when invalid)
//   pat    [3:0] : dash bits, bit 0 is sent first (0 when invalid)
module morse_rom
    import morse_pkg::*;
(
    input  logic [4:0] letter,
    output logic       valid,
    output logic [2:0] len,
    output logic [3:0] pat
);

    logic [6:0] entry;

    always_comb begin
        valid = (letter < 5'(LETTER_INVALID));
        entry = 7'd0;
        if (valid) begin
            entry = MORSE_TABLE[letter];
        end
    end

    assign len = entry[6:4];
    assign pat = entry[3:0];

endmodule

// File: rtl/morse_symbol_sequencer.sv
// morse_symbol_sequencer
// Plays one Morse letter per start request as timed marks and gaps, counted
// in tick pulses. UNIT_TICKS ticks make one Morse unit.
// Ports:
//   clk, reset (async, active-high)
//   tick      : time-base enable, single-cycle pulse
//   start     : play request, only looked at in IDLE
//   letter    : letter code, 0 = A ... 25 = Z
//   abort     : cancel playback
//   busy      : playback in progress
//   done      : one-cycle pulse after the last mark ends normally
//   err       : one-cycle pulse when start arrives with an invalid letter
//   tone_on   : high while a mark is sounding
//   sym_idx   : current symbol index
//   sym_len   : symbol count of the latched letter
//   sym_dash  : dash bits of the latched letter, bit 0 first
//   dbg_state : FSM state (IDLE = 0, MARK = 1, GAP = 2)
// Handshake: start is a level sampled on any clk edge in IDLE with abort low.
// There is no ready signal. busy high means a further start is ignored.
module morse_symbol_sequencer
    import morse_pkg::*;
#(
    parameter int UNIT_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic [4:0] letter,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       tone_on,
    output logic [1:0] sym_idx,
    output logic [2:0] sym_len,
    output logic [3:0] sym_dash,
    output logic [1:0] dbg_state
);

    localparam int CNT_W = $clog2(3 * UNIT_TICKS);

    // Counter reload values: a count of N-1 gives a phase that lasts N ticks.
    localparam logic [CNT_W-1:0] DASH_LOAD = CNT_W'(DASH_UNITS * UNIT_TICKS - 1);
    localparam logic [CNT_W-1:0] DOT_LOAD  = CNT_W'(DOT_UNITS * UNIT_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(UNIT_TICKS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic       rom_valid;
    logic [2:0] rom_len;
    logic [3:0] rom_pat;
    logic [1:0] next_idx;
    logic       last_sym;

    morse_rom u_rom (
        .letter (letter),
        .valid  (rom_valid),
        .len    (rom_len),
        .pat    (rom_pat)
    );

    assign next_idx  = sym_idx + 2'd1;
    assign last_sym  = ({1'b0, sym_idx} == (sym_len - 3'd1));
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            tone_on  <= 1'b0;
            sym_idx  <= 2'd0;
            sym_len  <= 3'd0;
            sym_dash <= 4'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    // abort has priority over start, and a cancelled start raises no err.
                    if (start && !abort) begin
                        if (rom_valid) begin
                            sym_len  <= rom_len;
                            sym_dash <= rom_pat;
                            sym_idx  <= 2'd0;
                            cnt      <= rom_pat[0] ? DASH_LOAD : DOT_LOAD;
                            state    <= MARK;
                            busy     <= 1'b1;
                            tone_on  <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                MARK: begin
                    if (abort) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        busy    <= 1'b0;
                        tone_on <= 1'b0;
                    end else if (tick) begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else if (last_sym) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            tone_on <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            state   <= GAP;
                            cnt     <= GAP_LOAD;
                            tone_on <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (tick) begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            sym_idx <= next_idx;
                            cnt     <= sym_dash[next_idx] ? DASH_LOAD : DOT_LOAD;
                            state   <= MARK;
                            tone_on <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    tone_on <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Bench for morse_symbol_sequencer with UNIT_TICKS = 2. Tick pulses once
// every three clocks. A monitor measures every tone and gap length in ticks
// and compares it against the expected queue that the scenario tasks fill.
module tb_morse_symbol_sequencer;

    localparam int UT = 2;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       start;
    logic [4:0] letter;
    logic       abort;
    logic       busy;
    logic       done;
    logic       err;
    logic       tone_on;
    logic [1:0] sym_idx;
    logic [2:0] sym_len;
    logic [3:0] sym_dash;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    // Entry format: {kind, length in ticks}, where kind 1 = tone and kind 0 = gap.
    logic [7:0] exp_q[$];

    int tone_ticks = 0;
    int gap_ticks  = 0;
    int tone_rises = 0;
    int done_cnt   = 0;
    logic prev_tone = 1'b0;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;
    int phase = 0;

    morse_symbol_sequencer #(.UNIT_TICKS(UT)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .start     (start),
        .letter    (letter),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .tone_on   (tone_on),
        .sym_idx   (sym_idx),
        .sym_len   (sym_len),
        .sym_dash  (sym_dash),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset / tick ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick  = (phase == 2);
            phase = (phase == 2) ? 0 : phase + 1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset) begin
            tone_ticks = 0;
            gap_ticks  = 0;
            prev_tone  = 1'b0;
            prev_busy  = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_tone && !tone_on) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tone_unexpected: tone of %0d ticks, none expected", tone_ticks);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if ({1'b1, 7'(tone_ticks)} !== e) begin
                        errors++;
                        $display("FAIL tone_len: got kind=1 len=%0d, expected kind=%0d len=%0d",
                                 tone_ticks, e[7], e[6:0]);
                    end
                end
                tone_ticks = 0;
            end
            if (prev_busy && !prev_tone && tone_on) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL gap_unexpected: gap of %0d ticks, none expected", gap_ticks);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if ({1'b0, 7'(gap_ticks)} !== e) begin
                        errors++;
                        $display("FAIL gap_len: got kind=0 len=%0d, expected kind=%0d len=%0d",
                                 gap_ticks, e[7], e[6:0]);
                    end
                end
                gap_ticks = 0;
            end
            if (!prev_tone && tone_on) tone_rises++;
            if (done) begin
                done_cnt++;
                checks++;
                if (prev_done) begin
                    errors++;
                    $display("FAIL done_width: done high 2 cycles, expected 1");
                end
            end
            if (!busy) gap_ticks = 0;
            if (tone_on && tick) tone_ticks++;
            if (busy && !tone_on && tick) gap_ticks++;
            prev_tone = tone_on;
            prev_busy = busy;
            prev_done = done;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_start(input logic [4:0] l);
        @(posedge clk); #2;
        letter = l;
        start  = 1'b1;
        @(posedge clk); #2;
        start  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: done=0 after 2000 cycles, expected 1", name);
        end
    endtask

    task automatic wait_rises(input int target, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tone_rises >= target) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: tone_rises=%0d, expected %0d", name, tone_rises, target);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err, tone_on, sym_idx, sym_len, sym_dash} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected 0",
                     {busy, done, err, tone_on, sym_idx, sym_len, sym_dash});
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d, expected 0", dbg_state);
        end
        @(posedge clk); #2;
        reset = 1'b0;
    endtask

    task automatic test_letter_e;
        int d0;
        d0 = done_cnt;
        exp_q.push_back({1'b1, 7'(UT)});
        drive_start(5'd4);
        @(negedge clk);
        checks++;
        if ({busy, tone_on, sym_idx, sym_len, sym_dash} !== {1'b1, 1'b1, 2'd0, 3'd1, 4'b0000}) begin
            errors++;
            $display("FAIL e_latch: busy=%b tone=%b idx=%0d len=%0d dash=%b, expected 1 1 0 1 0000",
                     busy, tone_on, sym_idx, sym_len, sym_dash);
        end
        wait_done("e");
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL e_busy_at_done: got %b, expected 0", busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL e_done_count: got %0d, expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_letter_a;
        int d0;
        int r0;
        d0 = done_cnt;
        r0 = tone_rises;
        exp_q.push_back({1'b1, 7'(UT)});
        exp_q.push_back({1'b0, 7'(UT)});
        exp_q.push_back({1'b1, 7'(3 * UT)});
        drive_start(5'd0);
        // A start for B while A is playing is ignored.
        drive_start(5'd1);
        @(negedge clk);
        checks++;
        if ({sym_len, sym_dash} !== {3'd2, 4'b0010}) begin
            errors++;
            $display("FAIL a_busy_start: len=%0d dash=%b, expected 2 0010", sym_len, sym_dash);
        end
        wait_rises(r0 + 2, "a_second_tone");
        checks++;
        if ({sym_idx, tone_on} !== {2'd1, 1'b1}) begin
            errors++;
            $display("FAIL a_sym_idx: idx=%0d tone=%b, expected 1 1", sym_idx, tone_on);
        end
        wait_done("a");
        checks++;
        if ({busy, sym_idx, sym_len, sym_dash} !== {1'b0, 2'd1, 3'd2, 4'b0010}) begin
            errors++;
            $display("FAIL a_end: busy=%b idx=%0d len=%0d dash=%b, expected 0 1 2 0010",
                     busy, sym_idx, sym_len, sym_dash);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL a_done_count: got %0d, expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_invalid;
        int d0;
        d0 = done_cnt;
        drive_start(5'd27);
        @(negedge clk);
        checks++;
        if ({err, busy, tone_on, done, sym_len} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd2}) begin
            errors++;
            $display("FAIL invalid_err: err=%b busy=%b tone=%b done=%b len=%0d, expected 1 0 0 0 2",
                     err, busy, tone_on, done, sym_len);
        end
        @(negedge clk);
        checks++;
        if ({err, busy, done_cnt - d0} !== {1'b0, 1'b0, 32'd0}) begin
            errors++;
            $display("FAIL invalid_after: err=%b busy=%b dones=%0d, expected 0 0 0",
                     err, busy, done_cnt - d0);
        end
    endtask

    task automatic test_abort;
        int d0;
        int r0;
        bit hit;
        d0 = done_cnt;
        r0 = tone_rises;
        exp_q.push_back({1'b1, 7'(3 * UT)});
        exp_q.push_back({1'b0, 7'(UT)});
        exp_q.push_back({1'b1, 7'd2});
        drive_start(5'd16);
        wait_rises(r0 + 2, "q_second_tone");
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tone_ticks >= 2) begin
                hit = 1;
                break;
            end
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL q_tick_timeout: tone_ticks=%0d, expected 2", tone_ticks);
        end
        @(posedge clk); #2;
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, tone_on, sym_len, sym_dash} !== {1'b0, 1'b0, 3'd4, 4'b1011}) begin
            errors++;
            $display("FAIL q_abort: busy=%b tone=%b len=%0d dash=%b, expected 0 0 4 1011",
                     busy, tone_on, sym_len, sym_dash);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 0) begin
            errors++;
            $display("FAIL q_no_done: got %0d, expected 0", done_cnt - d0);
        end
        exp_q.push_back({1'b1, 7'(3 * UT)});
        drive_start(5'd19);
        wait_done("t");
        checks++;
        if ({sym_len, sym_dash} !== {3'd1, 4'b0001}) begin
            errors++;
            $display("FAIL t_latch: len=%0d dash=%b, expected 1 0001", sym_len, sym_dash);
        end
    endtask

    task automatic test_abort_start_idle;
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        letter = 5'd2;
        start  = 1'b1;
        abort  = 1'b1;
        @(posedge clk); #2;
        letter = 5'd30;
        @(negedge clk);
        checks++;
        if ({busy, tone_on, err} !== 3'b000) begin
            errors++;
            $display("FAIL abort_start_valid: busy=%b tone=%b err=%b, expected 000", busy, tone_on, err);
        end
        @(posedge clk); #2;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, err, sym_len} !== {1'b0, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL abort_start_invalid: busy=%b err=%b len=%0d, expected 0 0 1", busy, err, sym_len);
        end
    endtask

    task automatic test_start_with_tick;
        bit hit;
        hit = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #2;
            if (tick === 1'b1) begin
                hit = 1;
                break;
            end
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL tick_align_timeout: tick=0, expected 1");
        end
        exp_q.push_back({1'b1, 7'(UT)});
        letter = 5'd4;
        start  = 1'b1;
        @(posedge clk); #2;
        start  = 1'b0;
        wait_done("tick_start");
    endtask

    task automatic test_reset_mid_gap;
        bit hit;
        exp_q.push_back({1'b1, 7'(UT)});
        drive_start(5'd0);
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy === 1'b1 && tone_on === 1'b0) begin
                hit = 1;
                break;
            end
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL gap_wait_timeout: no gap seen");
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, err, tone_on, sym_idx, sym_len, sym_dash} !== 13'd0) begin
            errors++;
            $display("FAIL async_reset: got %b, expected 0",
                     {busy, done, err, tone_on, sym_idx, sym_len, sym_dash});
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        letter = 5'd0;
        test_reset();
        test_letter_e();
        test_letter_a();
        test_invalid();
        test_abort();
        test_abort_start_idle();
        test_start_with_tick();
        test_reset_mid_gap();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/morse_symbol_sequencer.md
# morse_symbol_sequencer

Sequences playback of one Morse letter as a timed series of marks (dot or dash) and inter-symbol gaps, using a tick enable as the time base. Sits between letter-capture logic and the VGA morse display and tone driver. It drives the tone output and tells the display which symbol box is active and what each symbol is. One letter is played per start request; the block is idle otherwise.

## Interface
Parameters:
- UNIT_TICKS, default 8: tick pulses per Morse unit; must be ≥ 1.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  time-base enable; single-clk pulse.
- start  in  1  play request; sampled only in IDLE.
- letter  in  5  0=A … 25=Z; 26–31 invalid.
- abort  in  1  cancel playback.
- busy  out  1  high from the cycle after an accepted start until completion or abort.
- done  out  1  one-clk pulse when the last mark finishes normally.
- err  out  1  one-clk pulse when start arrives with an invalid letter.
- tone_on  out  1  high during MARK.
- sym_idx  out  2  index of the current symbol, 0..3.
- sym_len  out  3  symbol count of the latched letter, 1..4.
- sym_dash  out  4  bit i = 1 means symbol i is a dash; bit 0 is sent first; bits ≥ sym_len are 0.

## Operation
- States:
  - IDLE: waiting for a start request.
  - MARK: tone on for the current symbol.
  - GAP: one-unit silence between symbols.
- Reset (async): state=IDLE, cnt=0, and every output is 0.
- IDLE, start=1, valid letter, abort=0:
  - Latch sym_len and sym_dash from the ROM.
  - Set sym_idx=0 and enter MARK.
  - Load cnt = units·UNIT_TICKS − 1, where units = 3 for a dash and 1 for a dot.
- IDLE, start=1, invalid letter: pulse err; stay IDLE; latched sym_len, sym_dash and sym_idx are unchanged.
- MARK, on tick:
  - If cnt≠0, decrement cnt.
  - Else, if sym_idx = sym_len−1, go to IDLE and pulse done.
  - Else, go to GAP with cnt = UNIT_TICKS−1.
- GAP, on tick:
  - If cnt≠0, decrement cnt.
  - Else, increment sym_idx, enter MARK, and load cnt for the new symbol.
- abort=1 in MARK or GAP: go to IDLE on the next edge. tone_on=0 and busy=0; no done pulse. sym_* outputs hold their values.
- start while busy: ignored.
- abort and start together in IDLE: abort wins; start is ignored and err is not raised.
- Letters are held in the ROM as len[2:0] and pat[3:0], using the standard international code (A=.-, B=-..., … Z=--..).

## Timing
- All outputs are registered.
- Latency from start to output: busy and tone_on rise one clk after the start cycle.
- A tick in the same cycle as an accepted start is not counted.
- A mark lasts exactly units·UNIT_TICKS ticks; a gap lasts exactly UNIT_TICKS ticks.
- The MARK→GAP, GAP→MARK and MARK→IDLE transitions happen on the clk edge of the terminating tick.
- tone_on falls on that same edge.
- done is asserted for the single cycle following the final terminating tick. busy falls in that same cycle.
- cnt width is $clog2(3·UNIT_TICKS); the counter never wraps because it reloads on every transition.
- sym_idx never exceeds sym_len−1.

## Structure
- morse_pkg holds:
  - the state enum (IDLE, MARK, GAP);
  - the LETTER_INVALID threshold (26);
  - DASH_UNITS=3 and DOT_UNITS=1;
  - the 26-entry {len, pat} constant table.
- Sub-module morse_rom is a purely combinational lookup of letter → {valid, len, pat}.
- The sequencer holds the FSM, the counter and the output registers.

## Test plan
- UNIT_TICKS=2, letter=4 (E), start:
  - tone_on is high for exactly 2 ticks.
  - done pulses once; busy then 0.
  - sym_len=1, sym_dash=4'b0000.
- UNIT_TICKS=2, letter=0 (A):
  - tone 2 ticks, gap 2 ticks, tone 6 ticks.
  - sym_idx goes 0→1; sym_dash=4'b0010, sym_len=2; single done.
- letter=27, start: err pulses for 1 cycle; busy, tone_on and done stay 0; sym_len unchanged.
- letter=16 (Q, --.-), abort asserted during the second tone:
  - next cycle busy=0 and tone_on=0.
  - done is never pulsed.
  - A new start with letter=19 (T) then plays a 3-unit tone.
- During A playback:
  - start with letter=1 is ignored; sym_dash stays 4'b0010.
  - Asserting reset mid-GAP clears all outputs immediately, without waiting for a clk edge.
- start and tick coincide: the first tone still lasts the full UNIT_TICKS ticks, counted from the next tick.
